fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 23 ++
 rtl/fetch_next_pc.sv | 31 +++
 rtl/fetch_ctrl.sv | 110 +++++++++++
 tb/tb_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared core definitions for the instruction fetch controller: FSM encoding,
// PC-mux select codes and the default reset/trap vectors.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_TRAP  = 3'd4
    } fetch_state_e;

    localparam logic [1:0] PC_SRC_RESET = 2'b00;
    localparam logic [1:0] PC_SRC_RUN   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: sequential +4, taken branch, or trap vector.
// A misaligned branch target leaves the PC alone; the trap cycle redirects it.
module fetch_next_pc
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic [31:0] pc_in,
    input  logic        accept_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        trap_in,
    output logic [31:0] pc_next_out,
    output logic        misaligned_out
);

    always_comb begin
        misaligned_out = accept_in & branch_taken_in & is_misaligned(branch_target_in);
        pc_next_out    = pc_in;
        if (trap_in) begin
            pc_next_out = TRAP_VECTOR;
        end else if (accept_in) begin
            if (!branch_taken_in) begin
                pc_next_out = pc_in + 32'd4;
            end else if (!is_misaligned(branch_target_in)) begin
                pc_next_out = branch_target_in;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one bus request per instruction, holds
// the returned word until the consumer accepts it, then follows the redirect.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        ibus_req_out,
    output logic [31:0] ibus_addr_out,
    input  logic        ibus_gnt_in,
    input  logic        ibus_rvalid_in,
    input  logic [31:0] ibus_rdata_in,
    output logic [31:0] instr_out,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    output logic [31:0] pc_out,
    output logic [1:0]  pc_src_out,
    output logic        misaligned_out,
    output logic [31:0] trap_pc_out,
    output logic [31:0] retired_cnt_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  trap_pc_q, trap_pc_d;
    logic [31:0]  retired_cnt_q, retired_cnt_d;
    logic         accept;
    logic         branch_misaligned;

    assign accept = (state_q == ST_HOLD) && instr_ready_in;

    fetch_next_pc #(
        .TRAP_VECTOR(TRAP_VECTOR)
    ) u_next_pc (
        .pc_in           (pc_q),
        .accept_in       (accept),
        .branch_taken_in (branch_taken_in),
        .branch_target_in(branch_target_in),
        .trap_in         (state_q == ST_TRAP),
        .pc_next_out     (pc_d),
        .misaligned_out  (branch_misaligned)
    );

    // Read data is only looked at in WAIT, so late responses from an abandoned
    // transaction can never land in the instruction register.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        trap_pc_d     = trap_pc_q;
        retired_cnt_d = retired_cnt_q;
        case (state_q)
            ST_RESET: state_d = ST_REQ;
            ST_REQ: begin
                if (ibus_gnt_in) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ibus_rvalid_in) begin
                    instr_d = ibus_rdata_in;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    retired_cnt_d = retired_cnt_q + 32'd1;
                    if (branch_misaligned) begin
                        trap_pc_d = branch_target_in;
                        state_d   = ST_TRAP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_TRAP: state_d = ST_REQ;
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_RESET;
            pc_q          <= RESET_VECTOR;
            instr_q       <= 32'd0;
            trap_pc_q     <= 32'd0;
            retired_cnt_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            trap_pc_q     <= trap_pc_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign ibus_req_out    = (state_q == ST_REQ);
    assign ibus_addr_out   = pc_q;
    assign instr_valid_out = (state_q == ST_HOLD);
    assign instr_out       = instr_q;
    assign pc_out          = pc_q;
    assign pc_src_out      = (state_q == ST_RESET) ? PC_SRC_RESET : PC_SRC_RUN;
    assign misaligned_out  = (state_q == ST_TRAP);
    assign trap_pc_out     = trap_pc_q;
    assign retired_cnt_out = retired_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by randomized transactions,
// checked against a transaction-level model of the expected PC and retire count.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_VEC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        ibus_req_out;
    logic [31:0] ibus_addr_out;
    logic        ibus_gnt_in;
    logic        ibus_rvalid_in;
    logic [31:0] ibus_rdata_in;
    logic [31:0] instr_out;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic [31:0] pc_out;
    logic [1:0]  pc_src_out;
    logic        misaligned_out;
    logic [31:0] trap_pc_out;
    logic [31:0] retired_cnt_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    fetch_ctrl #(
        .RESET_VECTOR(RST_VEC),
        .TRAP_VECTOR (TRAP_VEC)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .ibus_req_out    (ibus_req_out),
        .ibus_addr_out   (ibus_addr_out),
        .ibus_gnt_in     (ibus_gnt_in),
        .ibus_rvalid_in  (ibus_rvalid_in),
        .ibus_rdata_in   (ibus_rdata_in),
        .instr_out       (instr_out),
        .instr_valid_out (instr_valid_out),
        .instr_ready_in  (instr_ready_in),
        .branch_taken_in (branch_taken_in),
        .branch_target_in(branch_target_in),
        .pc_out          (pc_out),
        .pc_src_out      (pc_src_out),
        .misaligned_out  (misaligned_out),
        .trap_pc_out     (trap_pc_out),
        .retired_cnt_out (retired_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Held in reset across a clock edge, then released; DUT ends in its first REQ cycle.
    task automatic do_reset();
        rst_in = 1'b1;
        ibus_gnt_in = 1'b0;
        ibus_rvalid_in = 1'b0;
        ibus_rdata_in = 32'd0;
        instr_ready_in = 1'b0;
        branch_taken_in = 1'b0;
        branch_target_in = 32'd0;
        tick();
        check("rst_req", {31'd0, ibus_req_out}, 32'd0);
        check("rst_valid", {31'd0, instr_valid_out}, 32'd0);
        check("rst_pc_src", {30'd0, pc_src_out}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned_out}, 32'd0);
        check("rst_retired", retired_cnt_out, 32'd0);
        check("rst_pc", pc_out, RST_VEC);
        check("rst_instr", instr_out, 32'd0);
        check("rst_trap_pc", trap_pc_out, 32'd0);
        rst_in = 1'b0;
        #1;
        check("post_rst_pc_src", {30'd0, pc_src_out}, 32'd0);
        check("post_rst_req", {31'd0, ibus_req_out}, 32'd0);
        tick();
        exp_pc = RST_VEC;
        exp_cnt = 32'd0;
    endtask

    // One complete instruction fetch, entered and left in a REQ cycle.
    task automatic fetch(input int gd, input int rd, input int hd, input bit br,
                         input logic [31:0] tgt);
        logic [31:0] word;
        word = $urandom;
        for (int i = 0; i <= gd; i++) begin
            check("req_high", {31'd0, ibus_req_out}, 32'd1);
            check("req_addr", ibus_addr_out, exp_pc);
            check("req_valid", {31'd0, instr_valid_out}, 32'd0);
            check("req_pc_src", {30'd0, pc_src_out}, 32'd3);
            ibus_gnt_in = (i == gd);
            ibus_rvalid_in = 1'($urandom_range(0, 1));
            ibus_rdata_in = $urandom;
            tick();
        end
        ibus_gnt_in = 1'b0;
        for (int i = 0; i <= rd; i++) begin
            check("wait_req", {31'd0, ibus_req_out}, 32'd0);
            check("wait_valid", {31'd0, instr_valid_out}, 32'd0);
            ibus_rvalid_in = (i == rd);
            ibus_rdata_in = (i == rd) ? word : $urandom;
            tick();
        end
        ibus_rvalid_in = 1'b0;
        for (int i = 0; i <= hd; i++) begin
            check("hold_valid", {31'd0, instr_valid_out}, 32'd1);
            check("hold_instr", instr_out, word);
            check("hold_pc", pc_out, exp_pc);
            check("hold_req", {31'd0, ibus_req_out}, 32'd0);
            check("hold_retired", retired_cnt_out, exp_cnt);
            if (i == hd) begin
                instr_ready_in = 1'b1;
                branch_taken_in = br;
                branch_target_in = tgt;
                ibus_rvalid_in = 1'b0;
            end else begin
                instr_ready_in = 1'b0;
                branch_taken_in = 1'(i & 1);
                branch_target_in = $urandom;
                ibus_rvalid_in = 1'($urandom_range(0, 1));
                ibus_rdata_in = $urandom;
            end
            tick();
        end
        instr_ready_in = 1'b0;
        branch_taken_in = 1'b0;
        ibus_rvalid_in = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        if (br && (tgt % 4 != 0)) begin
            check("trap_pulse", {31'd0, misaligned_out}, 32'd1);
            check("trap_pc", trap_pc_out, tgt);
            check("trap_valid", {31'd0, instr_valid_out}, 32'd0);
            check("trap_retired", retired_cnt_out, exp_cnt);
            exp_pc = TRAP_VEC;
            tick();
        end else if (br) begin
            exp_pc = tgt;
        end else begin
            exp_pc = exp_pc + 32'd4;
        end
        check("after_misaligned", {31'd0, misaligned_out}, 32'd0);
        check("after_retired", retired_cnt_out, exp_cnt);
    endtask

    initial begin
        logic [31:0] tgt;
        bit          br;

        // Back-to-back fetches at full rate.
        do_reset();
        fetch(0, 0, 0, 1'b0, 32'd0);
        fetch(0, 0, 0, 1'b0, 32'd0);
        fetch(0, 0, 0, 1'b0, 32'd0);
        check("seq_addr_12", ibus_addr_out, 32'h0000_000C);
        check("seq_retired_3", retired_cnt_out, 32'd3);

        // Delayed grant at address 4, then long hold and aligned branch.
        do_reset();
        fetch(0, 0, 0, 1'b0, 32'd0);
        fetch(4, 0, 0, 1'b0, 32'd0);
        fetch(0, 1, 5, 1'b1, 32'h0000_0040);
        check("branch_addr_40", ibus_addr_out, 32'h0000_0040);

        // Misaligned branch target traps to the trap vector.
        fetch(0, 0, 0, 1'b1, 32'h0000_0042);
        check("trap_vec_addr", ibus_addr_out, 32'h0000_0100);

        // Reset in WAIT; stale response arriving in REQ is dropped.
        ibus_gnt_in = 1'b1;
        tick();
        ibus_gnt_in = 1'b0;
        check("pre_abort_req", {31'd0, ibus_req_out}, 32'd0);
        rst_in = 1'b1;
        #2;
        check("async_pc_src", {30'd0, pc_src_out}, 32'd0);
        check("async_retired", retired_cnt_out, 32'd0);
        tick();
        rst_in = 1'b0;
        tick();
        exp_pc = RST_VEC;
        exp_cnt = 32'd0;
        ibus_rvalid_in = 1'b1;
        ibus_rdata_in = 32'hDEAD_BEEF;
        check("stale_addr", ibus_addr_out, 32'd0);
        tick();
        ibus_rvalid_in = 1'b0;
        check("stale_valid", {31'd0, instr_valid_out}, 32'd0);
        check("stale_still_req", {31'd0, ibus_req_out}, 32'd1);
        check("stale_addr2", ibus_addr_out, 32'd0);
        fetch(0, 2, 0, 1'b0, 32'd0);

        // PC wrap at the top of the address space.
        fetch(0, 0, 0, 1'b1, 32'hFFFF_FFFC);
        check("top_addr", ibus_addr_out, 32'hFFFF_FFFC);
        fetch(0, 0, 0, 1'b0, 32'd0);
        check("wrap_addr", ibus_addr_out, 32'h0000_0000);

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            br = ($urandom_range(0, 3) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt = tgt & 32'hFFFF_FFFC;
            fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br, tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
